// File: rtl/field_tri_pkg.sv
// Shared defaults and helpers for the odd/even field trigger generator.
package field_tri_pkg;

  localparam int N_CH_DEF        = 2;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_LEN_DEF    = 4;
  localparam int CNT_W_DEF       = 24;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_e;

  // Width of the filter stability counter; never narrower than one bit.
  function automatic int fcnt_w(input int filt_len);
    return (filt_len > 1) ? $clog2(filt_len) : 1;
  endfunction

endpackage

// File: rtl/field_tri_chan.sv
// One field channel: input synchroniser, glitch filter, edge pulses and
// odd-to-odd period measurement.
module field_tri_chan
  import field_tri_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             oe_raw,
  input  logic             en,
  output logic             odd_tri,
  output logic             even_tri,
  output logic             oe_filt,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             period_ovf
);

  localparam int               FW       = fcnt_w(FILT_LEN);
  localparam logic [FW-1:0]    FCNT_TC  = FW'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] PCNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic [FW-1:0]          fcnt_q;
  logic [CNT_W-1:0]       pcnt_q;
  logic                   armed_q;
  edge_e                  edge_d;

  // Synchroniser keeps running while the channel is disabled.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], oe_raw};
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_d = EDGE_NONE;
    if (en && (sync_lvl != oe_filt) && (fcnt_q == FCNT_TC))
      edge_d = sync_lvl ? EDGE_RISE : EDGE_FALL;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      oe_filt  <= 1'b0;
      fcnt_q   <= '0;
      odd_tri  <= 1'b0;
      even_tri <= 1'b0;
    end else if (!en) begin
      oe_filt  <= 1'b0;
      fcnt_q   <= '0;
      odd_tri  <= 1'b0;
      even_tri <= 1'b0;
    end else begin
      odd_tri  <= (edge_d == EDGE_RISE);
      even_tri <= (edge_d == EDGE_FALL);
      if ((sync_lvl == oe_filt) || (edge_d != EDGE_NONE)) fcnt_q <= '0;
      else                                               fcnt_q <= fcnt_q + FW'(1);
      if (edge_d != EDGE_NONE) oe_filt <= sync_lvl;
    end
  end

  // period/period_ovf survive a disable; only the running measurement is dropped.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q     <= '0;
      armed_q    <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      period_ovf <= 1'b0;
    end else if (!en) begin
      pcnt_q     <= '0;
      armed_q    <= 1'b0;
      period_vld <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (edge_d == EDGE_RISE) begin
        if (armed_q) begin
          period     <= pcnt_q;
          period_vld <= 1'b1;
          period_ovf <= (pcnt_q == PCNT_MAX);
        end
        pcnt_q  <= CNT_W'(1);
        armed_q <= 1'b1;
      end else if (pcnt_q != PCNT_MAX) begin
        pcnt_q <= pcnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/oe_field_tri_mc.sv
// Multi-channel odd/even field trigger generator for the video-trigger path;
// one independent field_tri_chan per channel, buses flattened per channel.
module oe_field_tri_mc
  import field_tri_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       oe_in,
  input  logic [N_CH-1:0]       ch_en,
  output logic [N_CH-1:0]       odd_field_tri,
  output logic [N_CH-1:0]       even_field_tri,
  output logic [N_CH-1:0]       oe_filt,
  output logic [N_CH*CNT_W-1:0] period,
  output logic [N_CH-1:0]       period_vld,
  output logic [N_CH-1:0]       period_ovf
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    field_tri_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .oe_raw     (oe_in[i]),
      .en         (ch_en[i]),
      .odd_tri    (odd_field_tri[i]),
      .even_tri   (even_field_tri[i]),
      .oe_filt    (oe_filt[i]),
      .period     (period[i*CNT_W +: CNT_W]),
      .period_vld (period_vld[i]),
      .period_ovf (period_ovf[i])
    );
  end

endmodule

// File: tb/tb_oe_field_tri_mc.sv
// Bench for oe_field_tri_mc: a default-width instance and an 8-bit-counter
// instance share stimulus and are both checked every cycle against a model.
module tb_oe_field_tri_mc;

  localparam int NC   = 2;
  localparam int SS   = 2;
  localparam int FL   = 4;
  localparam int CW_A = 24;
  localparam int CW_B = 8;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic [NC-1:0] oe_in = '0;
  logic [NC-1:0] ch_en = '0;

  logic [NC-1:0]      a_odd, a_even, a_filt, a_vld, a_ovf;
  logic [NC*CW_A-1:0] a_per;
  logic [NC-1:0]      b_odd, b_even, b_filt, b_vld, b_ovf;
  logic [NC*CW_B-1:0] b_per;

  oe_field_tri_mc #(.N_CH(NC), .SYNC_STAGES(SS), .FILT_LEN(FL), .CNT_W(CW_A)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .oe_in(oe_in), .ch_en(ch_en),
    .odd_field_tri(a_odd), .even_field_tri(a_even), .oe_filt(a_filt),
    .period(a_per), .period_vld(a_vld), .period_ovf(a_ovf));

  oe_field_tri_mc #(.N_CH(NC), .SYNC_STAGES(SS), .FILT_LEN(FL), .CNT_W(CW_B)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .oe_in(oe_in), .ch_en(ch_en),
    .odd_field_tri(b_odd), .even_field_tri(b_even), .oe_filt(b_filt),
    .period(b_per), .period_vld(b_vld), .period_ovf(b_ovf));

  always #5 clk_in = ~clk_in;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: raw-sample log, window of recent filtered-path samples,
  // and timestamps of odd triggers.
  int     cyc     = 0;
  int     rst_cyc = 0;
  bit     raw_at  [NC][64];
  bit [FL-1:0] m_win [2][NC];
  int     m_wn    [2][NC];
  bit     m_filt  [2][NC];
  bit     m_odd   [2][NC];
  bit     m_even  [2][NC];
  bit     m_vld   [2][NC];
  bit     m_ovf   [2][NC];
  bit     m_armed [2][NC];
  longint m_per   [2][NC];
  int     m_last  [2][NC];

  int n_odd  [2][NC];
  int n_even [2][NC];
  int n_vld  [2][NC];

  typedef struct {
    logic [NC-1:0] oe;
    logic [NC-1:0] en;
    int            cyc;
    int            odd0;
    int            even0;
    int            odd1;
    int            even1;
    logic [NC-1:0] filt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input int k, input int c, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      if (mismatched <= 30)
        $display("FAIL %s [dut%0d ch%0d] t=%0t: got %0d, required %0d", nm, k, c, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    rst_cyc = cyc;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NC; c++) begin
        m_win[k][c] = '0;  m_wn[k][c] = 0;    m_filt[k][c] = 1'b0;
        m_odd[k][c] = 1'b0; m_even[k][c] = 1'b0; m_vld[k][c] = 1'b0;
        m_ovf[k][c] = 1'b0; m_armed[k][c] = 1'b0; m_per[k][c] = 0; m_last[k][c] = 0;
      end
  endfunction

  function automatic void model_step();
    cyc++;
    for (int c = 0; c < NC; c++) begin
      bit seen;
      seen = ((cyc - SS) > rst_cyc) ? raw_at[c][(cyc - SS) % 64] : 1'b0;
      raw_at[c][cyc % 64] = oe_in[c];
      for (int k = 0; k < 2; k++) begin
        m_odd[k][c] = 1'b0; m_even[k][c] = 1'b0; m_vld[k][c] = 1'b0;
        if (!ch_en[c]) begin
          m_filt[k][c] = 1'b0; m_wn[k][c] = 0; m_armed[k][c] = 1'b0;
        end else begin
          m_win[k][c] = {m_win[k][c][FL-2:0], seen};
          if (m_wn[k][c] < FL) m_wn[k][c]++;
          if (m_wn[k][c] == FL && m_win[k][c] == {FL{~m_filt[k][c]}}) begin
            m_filt[k][c] = seen;
            if (seen) m_odd[k][c] = 1'b1;
            else      m_even[k][c] = 1'b1;
          end
          if (m_odd[k][c]) begin
            if (m_armed[k][c]) begin
              longint p, mx;
              p  = cyc - m_last[k][c];
              mx = (k == 0) ? ((64'd1 << CW_A) - 1) : ((64'd1 << CW_B) - 1);
              m_vld[k][c] = 1'b1;
              m_ovf[k][c] = (p >= mx);
              m_per[k][c] = (p >= mx) ? mx : p;
            end
            m_last[k][c]  = cyc;
            m_armed[k][c] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NC; c++) begin
        chk("odd",  k, c, longint'(k == 0 ? a_odd[c]  : b_odd[c]),  longint'(m_odd[k][c]));
        chk("even", k, c, longint'(k == 0 ? a_even[c] : b_even[c]), longint'(m_even[k][c]));
        chk("filt", k, c, longint'(k == 0 ? a_filt[c] : b_filt[c]), longint'(m_filt[k][c]));
        chk("vld",  k, c, longint'(k == 0 ? a_vld[c]  : b_vld[c]),  longint'(m_vld[k][c]));
        chk("ovf",  k, c, longint'(k == 0 ? a_ovf[c]  : b_ovf[c]),  longint'(m_ovf[k][c]));
        chk("period", k, c, (k == 0) ? longint'(a_per[c*CW_A +: CW_A]) : longint'(b_per[c*CW_B +: CW_B]),
            m_per[k][c]);
      end
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NC; c++) begin
        n_odd[k][c] = 0; n_even[k][c] = 0; n_vld[k][c] = 0;
      end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_step();
    #1;
    check_all();
    for (int c = 0; c < NC; c++) begin
      n_odd[0][c]  += int'(a_odd[c]);  n_odd[1][c]  += int'(b_odd[c]);
      n_even[0][c] += int'(a_even[c]); n_even[1][c] += int'(b_even[c]);
      n_vld[0][c]  += int'(a_vld[c]);  n_vld[1][c]  += int'(b_vld[c]);
    end
  endtask

  task automatic sq(input int c, input int half, input int n);
    for (int p = 0; p < n; p++) begin
      oe_in[c] = 1'b1;
      repeat (half) step();
      oe_in[c] = 1'b0;
      repeat (half) step();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, first1;

    tbl[0]  = '{2'b00, 2'b11, 10, 0, 0, 0, 0, 2'b00};
    tbl[1]  = '{2'b01, 2'b11, 10, 1, 0, 0, 0, 2'b01};
    tbl[2]  = '{2'b11, 2'b11, 10, 0, 0, 1, 0, 2'b11};
    tbl[3]  = '{2'b10, 2'b11, 10, 0, 1, 0, 0, 2'b10};
    tbl[4]  = '{2'b10, 2'b01, 10, 0, 0, 0, 0, 2'b00};
    tbl[5]  = '{2'b10, 2'b11,  3, 0, 0, 0, 0, 2'b00};
    tbl[6]  = '{2'b10, 2'b11,  2, 0, 0, 1, 0, 2'b10};
    tbl[7]  = '{2'b00, 2'b11, 10, 0, 0, 0, 1, 2'b00};
    tbl[8]  = '{2'b11, 2'b11,  5, 0, 0, 0, 0, 2'b00};
    tbl[9]  = '{2'b11, 2'b11,  1, 1, 0, 1, 0, 2'b11};
    tbl[10] = '{2'b00, 2'b00, 10, 0, 0, 0, 0, 2'b00};

    // Reset state
    model_reset();
    ch_en = '1;
    #23;
    check_all();
    @(negedge clk_in);
    rst_n = 1'b1;

    // Rising field after reset: single odd pulse on the 6th edge
    repeat (2) step();
    clr_cnt();
    oe_in[0] = 1'b1;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (a_odd[0] && first == 0) first = i;
    end
    chk("latency_odd0", -1, 0, first, 6);
    chk("filt_after_rise", -1, 0, longint'(a_filt[0]), 1);
    chk("odd_count_rise", -1, 0, n_odd[0][0], 1);
    chk("even_count_rise", -1, 0, n_even[0][0], 0);
    oe_in[0] = 1'b0;
    repeat (10) step();

    // Table of held input patterns
    for (int r = 0; r < 11; r++) begin
      oe_in = tbl[r].oe;
      ch_en = tbl[r].en;
      clr_cnt();
      repeat (tbl[r].cyc) step();
      chk($sformatf("tbl%0d_odd0", r),  -1, 0, n_odd[0][0],  tbl[r].odd0);
      chk($sformatf("tbl%0d_even0", r), -1, 0, n_even[0][0], tbl[r].even0);
      chk($sformatf("tbl%0d_odd1", r),  -1, 1, n_odd[0][1],  tbl[r].odd1);
      chk($sformatf("tbl%0d_even1", r), -1, 1, n_even[0][1], tbl[r].even1);
      chk($sformatf("tbl%0d_filt", r),  -1, -1, longint'(a_filt), longint'(tbl[r].filt));
    end

    // Glitches on channel 1: 3 samples rejected, 4 accepted
    ch_en = '1;
    oe_in = '0;
    repeat (10) step();
    clr_cnt();
    oe_in[1] = 1'b1; repeat (3) step();
    oe_in[1] = 1'b0; repeat (10) step();
    chk("glitch3_odd1", -1, 1, n_odd[0][1], 0);
    chk("glitch3_filt1", -1, 1, longint'(a_filt[1]), 0);
    oe_in[1] = 1'b1; repeat (4) step();
    oe_in[1] = 1'b0; repeat (12) step();
    chk("glitch4_odd1", -1, 1, n_odd[0][1], 1);
    chk("glitch4_even1", -1, 1, n_even[0][1], 1);

    // Period 1000 from a fresh enable
    ch_en[0] = 1'b0;
    repeat (3) step();
    ch_en[0] = 1'b1;
    repeat (5) step();
    clr_cnt();
    sq(0, 500, 3);
    chk("p1000_odd", -1, 0, n_odd[0][0], 3);
    chk("p1000_vld", -1, 0, n_vld[0][0], 2);
    chk("p1000_period", -1, 0, longint'(a_per[CW_A-1:0]), 1000);
    chk("p1000_ovf", -1, 0, longint'(a_ovf[0]), 0);
    chk("p1000_b_period", -1, 0, longint'(b_per[CW_B-1:0]), 255);

    // Saturation on the 8-bit instance, then recovery
    sq(0, 150, 3);
    chk("p300_b_period", -1, 0, longint'(b_per[CW_B-1:0]), 255);
    chk("p300_b_ovf", -1, 0, longint'(b_ovf[0]), 1);
    chk("p300_a_period", -1, 0, longint'(a_per[CW_A-1:0]), 300);
    sq(0, 50, 3);
    chk("p100_b_period", -1, 0, longint'(b_per[CW_B-1:0]), 100);
    chk("p100_b_ovf", -1, 0, longint'(b_ovf[0]), 0);

    // Disabled channel ignores toggling, keeps last period
    ch_en[0] = 1'b0;
    clr_cnt();
    sq(0, 20, 3);
    chk("dis_odd0", -1, 0, n_odd[0][0], 0);
    chk("dis_even0", -1, 0, n_even[0][0], 0);
    chk("dis_period", -1, 0, longint'(a_per[CW_A-1:0]), 100);
    chk("dis_filt0", -1, 0, longint'(a_filt[0]), 0);

    // Re-enable together with a rising input
    oe_in[0] = 1'b1;
    ch_en[0] = 1'b1;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (a_odd[0] && first == 0) first = i;
    end
    chk("reen_latency", -1, 0, first, 6);
    chk("reen_no_vld", -1, 0, n_vld[0][0], 0);
    repeat (50) step();
    oe_in[0] = 1'b0; repeat (60) step();
    oe_in[0] = 1'b1; repeat (30) step();
    oe_in[0] = 1'b0; repeat (10) step();
    chk("reen_vld", -1, 0, n_vld[0][0], 1);
    chk("reen_period", -1, 0, longint'(a_per[CW_A-1:0]), 120);
    chk("reen_b_period", -1, 0, longint'(b_per[CW_B-1:0]), 120);

    // Randomised run lengths, some short enough to be glitches, some long
    for (int r = 0; r < 400; r++) begin
      int len;
      oe_in = NC'($urandom_range(0, 3));
      ch_en = ($urandom_range(0, 9) == 0) ? NC'($urandom_range(0, 3)) : '1;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 320) : $urandom_range(1, 10);
      repeat (len) step();
    end

    // Reset mid-field with inputs high
    oe_in = '1;
    ch_en = '1;
    repeat (20) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_filt_now", -1, -1, longint'(a_filt), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    first  = 0;
    first1 = 0;
    clr_cnt();
    for (int i = 1; i <= 10; i++) begin
      step();
      if (a_odd[0] && first == 0)  first = i;
      if (a_odd[1] && first1 == 0) first1 = i;
    end
    chk("rst_latency0", -1, 0, first, 6);
    chk("rst_latency1", -1, 1, first1, 6);
    chk("rst_no_vld", -1, 0, n_vld[0][0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
